// File: rtl/cache_line_mem_if.sv
// Request/response bundle between the cache (master) and the line memory (slave).
interface cache_line_mem_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] data;
  logic        wvalid;
  logic        ready;
  logic [31:0] q;
  logic        q_valid;
  logic        ack;

  modport master (
    output req, wr, addr, data, wvalid,
    input  ready, q, q_valid, ack
  );

  modport slave (
    input  req, wr, addr, data, wvalid,
    output ready, q, q_valid, ack
  );
endinterface

// File: rtl/cache_line_mem.sv
// Latency-bearing line memory: serves whole-line refills and write-backs
// as bursts of LINE_WORDS consecutive words from an internal word array.
module cache_line_mem #(
  parameter int DEPTH_WORDS = 256,
  parameter int LINE_WORDS  = 4,
  parameter int LATENCY     = 3
) (
  input logic             clk,
  input logic             rst,
  cache_line_mem_if.slave bus
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [LW-1:0] LAST_WAIT = LW'(LATENCY - 1);
  localparam logic [IW-1:0] LINE_MASK = IW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_WR_DATA,
    S_WR_WAIT,
    S_WR_ACK
  } state_t;

  state_t          state, state_n;
  logic [BW-1:0]   beat, beat_n;
  logic [LW-1:0]   lat_cnt, lat_n;
  logic [IW-1:0]   base, base_n;
  logic [31:0]     q_r, q_n;
  logic            mem_we;
  logic [IW-1:0]   mem_waddr;

  // Starts zeroed at simulation start; rst deliberately leaves it alone.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  // Address bits above the array size alias silently.
  logic addr_high_unused;
  assign addr_high_unused = ^bus.addr[31:IW];

  // State, counters, captured line base and the registered read beat.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      beat    <= '0;
      lat_cnt <= '0;
      base    <= '0;
      q_r     <= '0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      lat_cnt <= lat_n;
      base    <= base_n;
      q_r     <= q_n;
    end
  end

  // Write beats land in the array at the edge that samples them.
  // NOTE: the array has no reset branch on purpose: clearing a memory costs a
  // port per word and would also destroy data that must survive rst.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= bus.data;
  end

  // Next-state, counter updates and the next read beat.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    beat_n    = beat;
    lat_n     = lat_cnt;
    base_n    = base;
    q_n       = '0;
    mem_we    = 1'b0;
    mem_waddr = base + IW'(beat);
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          base_n  = bus.addr[IW-1:0] & ~LINE_MASK;
          beat_n  = '0;
          lat_n   = '0;
          state_n = bus.wr ? S_WR_DATA : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_cnt == LAST_WAIT) begin
          lat_n   = '0;
          state_n = S_RD_BURST;
          q_n     = mem[base];
        end else begin
          lat_n = lat_cnt + LW'(1);
        end
      end
      S_RD_BURST: begin
        if (beat == LAST_BEAT) begin
          beat_n  = '0;
          state_n = S_IDLE;
        end else begin
          beat_n = beat + BW'(1);
          q_n    = mem[base + IW'(beat_n)];
        end
      end
      S_WR_DATA: begin
        if (bus.wvalid) begin
          mem_we = 1'b1;
          if (beat == LAST_BEAT) begin
            beat_n  = '0;
            lat_n   = '0;
            state_n = S_WR_WAIT;
          end else begin
            beat_n = beat + BW'(1);
          end
        end
      end
      S_WR_WAIT: begin
        if (lat_cnt == LAST_WAIT) begin
          lat_n   = '0;
          state_n = S_WR_ACK;
        end else begin
          lat_n = lat_cnt + LW'(1);
        end
      end
      S_WR_ACK: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  assign bus.ready   = (state == S_IDLE);
  assign bus.q_valid = (state == S_RD_BURST);
  assign bus.ack     = (state == S_WR_ACK);
  assign bus.q       = q_r;

endmodule

// File: tb/tb_cache_line_mem.sv
// Self-checking bench for cache_line_mem: directed scenarios plus random
// traffic, all checked against a plain word-array model and cycle offsets.
module tb_cache_line_mem;
  localparam int DEPTH = 256;
  localparam int LW    = 4;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_line_mem_if bus ();

  cache_line_mem #(
    .DEPTH_WORDS(DEPTH),
    .LINE_WORDS (LW),
    .LATENCY    (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] beat_data [LW];
  int          beat_gap  [LW];

  function automatic int line_base(input logic [31:0] a);
    return int'(a % DEPTH) / LW * LW;
  endfunction

  task automatic drive_idle();
    bus.req    = 1'b0;
    bus.wr     = 1'b0;
    bus.addr   = '0;
    bus.wvalid = 1'b0;
    bus.data   = $urandom;
  endtask

  // Issue a read and follow it cycle by cycle after the accept edge E0.
  // abort_beat >= 0 asserts rst while that beat is on q.
  task automatic read_line(input logic [31:0] a, input int abort_beat,
                           input bit busy_pulse, input string tag);
    int base;
    logic        exp_valid, exp_ready;
    logic [31:0] exp_q;
    base = line_base(a);
    bus.req    = 1'b1;
    bus.wr     = 1'b0;
    bus.addr   = a;
    bus.wvalid = 1'($urandom_range(0, 1));
    bus.data   = $urandom;
    @(posedge clk); #1;
    bus.req = 1'b0;
    for (int j = 0; j <= LAT + LW; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      exp_valid = (j >= LAT) && (j < LAT + LW);
      exp_q     = exp_valid ? model_mem[base + j - LAT] : 32'h0;
      exp_ready = (j >= LAT + LW);
      n_tests++;
      if (bus.q_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL %s q_valid j=%0d got %b exp %b", tag, j, bus.q_valid, exp_valid);
      end
      n_tests++;
      if (bus.q !== exp_q) begin
        n_fail++;
        $display("FAIL %s q j=%0d got %h exp %h", tag, j, bus.q, exp_q);
      end
      n_tests++;
      if (bus.ready !== exp_ready || bus.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ready/ack j=%0d got %b/%b exp %b/0", tag, j, bus.ready, bus.ack, exp_ready);
      end
      bus.wvalid = 1'($urandom_range(0, 1));
      bus.data   = $urandom;
      if (busy_pulse) begin
        bus.req  = (j == 0);
        bus.wr   = 1'b0;
        bus.addr = 32'd12;
      end
      if (abort_beat >= 0 && j == LAT + abort_beat) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (bus.q_valid !== 1'b0 || bus.q !== 32'h0 || bus.ready !== 1'b1 || bus.ack !== 1'b0) begin
          n_fail++;
          $display("FAIL %s after_reset got valid=%b q=%h ready=%b ack=%b exp 0/0/1/0",
                   tag, bus.q_valid, bus.q, bus.ready, bus.ack);
        end
        drive_idle();
        return;
      end
    end
    drive_idle();
    if (busy_pulse) begin
      for (int j = 0; j <= LAT + 1; j++) begin
        @(posedge clk); #1;
        n_tests++;
        if (bus.q_valid !== 1'b0 || bus.ready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s no_second_burst j=%0d got valid=%b ready=%b exp 0/1",
                   tag, j, bus.q_valid, bus.ready);
        end
      end
    end
  endtask

  // Issue a write of beat_data with beat_gap idle cycles before each beat.
  // abort_after < LW asserts rst together with beat number abort_after.
  task automatic write_line(input logic [31:0] a, input int abort_after, input string tag);
    int base;
    base = line_base(a);
    bus.req    = 1'b1;
    bus.wr     = 1'b1;
    bus.addr   = a;
    bus.wvalid = 1'b0;
    bus.data   = beat_data[0] ^ 32'hdead_beef;
    @(posedge clk); #1;
    bus.req = 1'b0;
    for (int k = 0; k < LW; k++) begin
      repeat (beat_gap[k]) begin
        bus.wvalid = 1'b0;
        bus.data   = $urandom;
        @(posedge clk); #1;
        n_tests++;
        if (bus.ready !== 1'b0 || bus.ack !== 1'b0) begin
          n_fail++;
          $display("FAIL %s gap k=%0d got ready=%b ack=%b exp 0/0", tag, k, bus.ready, bus.ack);
        end
      end
      bus.wvalid = 1'b1;
      bus.data   = beat_data[k];
      if (k == abort_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        for (int j = 0; j <= LAT + 1; j++) begin
          if (j > 0) begin @(posedge clk); #1; end
          n_tests++;
          if (bus.ack !== 1'b0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s aborted j=%0d got ack=%b ready=%b exp 0/1", tag, j, bus.ack, bus.ready);
          end
        end
        return;
      end
      @(posedge clk); #1;
      model_mem[base + k] = beat_data[k];
      n_tests++;
      if (bus.ready !== 1'b0 || bus.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL %s beat k=%0d got ready=%b ack=%b exp 0/0", tag, k, bus.ready, bus.ack);
      end
    end
    for (int j = 1; j <= LAT + 1; j++) begin
      bus.wvalid = 1'($urandom_range(0, 1));
      bus.data   = $urandom;
      @(posedge clk); #1;
      n_tests++;
      if (bus.ack !== (j == LAT) || bus.ready !== (j == LAT + 1)) begin
        n_fail++;
        $display("FAIL %s ack_timing j=%0d got ack=%b ready=%b exp %b/%b",
                 tag, j, bus.ack, bus.ready, (j == LAT), (j == LAT + 1));
      end
    end
    drive_idle();
  endtask

  task automatic set_beats(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input int g0, input int g1, input int g2, input int g3);
    beat_data[0] = d0; beat_data[1] = d1; beat_data[2] = d2; beat_data[3] = d3;
    beat_gap[0]  = g0; beat_gap[1]  = g1; beat_gap[2]  = g2; beat_gap[3]  = g3;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if (bus.ready !== 1'b1 || bus.q_valid !== 1'b0 || bus.ack !== 1'b0 || bus.q !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state got ready=%b valid=%b ack=%b q=%h exp 1/0/0/0",
               bus.ready, bus.q_valid, bus.ack, bus.q);
    end
  endtask

  task automatic test_write_read();
    set_beats(32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 0);
    write_line(32'd0, LW, "wr_basic");
    read_line(32'd2, -1, 1'b0, "rd_basic");
  endtask

  task automatic test_gapped_write();
    set_beats(32'hA, 32'hB, 32'hC, 32'hD, 0, 1, 2, 0);
    write_line(32'd8, LW, "wr_gapped");
    read_line(32'd8, -1, 1'b0, "rd_gapped");
  endtask

  task automatic test_alias();
    set_beats(32'h55, 32'h55, 32'h55, 32'h55, 0, 0, 0, 0);
    write_line(32'(DEPTH + 4), LW, "wr_alias");
    read_line(32'd4, -1, 1'b0, "rd_alias");
    read_line(32'd0, -1, 1'b0, "rd_alias_low");
  endtask

  task automatic test_busy();
    read_line(32'd4, -1, 1'b1, "rd_busy");
  endtask

  task automatic test_reset_mid_read();
    read_line(32'd9, 2, 1'b0, "rd_abort");
    read_line(32'd8, -1, 1'b0, "rd_after_abort");
  endtask

  task automatic test_reset_mid_write();
    set_beats(32'h100, 32'h101, 32'h102, 32'h103, 0, 0, 0, 0);
    write_line(32'd16, LW, "wr_prefill");
    set_beats(32'h7, 32'h8, 32'h9, 32'hA, 0, 0, 0, 0);
    write_line(32'd16, 2, "wr_abort");
    read_line(32'd16, -1, 1'b0, "rd_after_wr_abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < LW; k++) begin
          beat_data[k] = $urandom;
          beat_gap[k]  = $urandom_range(0, 2);
        end
        write_line(a, LW, "rnd_wr");
      end else begin
        read_line(a, -1, 1'b0, "rnd_rd");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    drive_idle();
    test_reset();
    test_write_read();
    test_gapped_write();
    test_alias();
    test_busy();
    test_reset_mid_read();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
